// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: gathers `pack` bytes into one word on a valid/ready stream.
// A flush pushes out any partial word, with m_keep marking which bytes are valid.
module fifo_rd_packer #(
    parameter int data_width = 8,
    parameter int pack       = 4,
    parameter int cnt_width  = 16
) (
    input  logic                       rclk,
    input  logic                       r_rst_n,
    input  logic                       empty,
    output logic                       r_en,
    input  logic [data_width-1:0]      fifo_data,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [data_width*pack-1:0] m_data,
    output logic [pack-1:0]            m_keep,
    output logic                       busy,
    output logic [cnt_width-1:0]       word_cnt
);

    localparam int CW  = $clog2(pack + 1);
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {FILL, DRAIN, EMIT} state_e;

    state_e                             state_q, state_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               inflight_q, inflight_d;
    logic                               flush_pend_q, flush_pend_d;
    logic [pack-1:0][data_width-1:0]    acc_q, acc_d;
    logic                               m_valid_q, m_valid_d;
    logic [pack-1:0][data_width-1:0]    m_data_q, m_data_d;
    logic [pack-1:0]                    m_keep_q, m_keep_d;
    logic [cnt_width-1:0]               word_cnt_q, word_cnt_d;

    logic [pack-1:0][data_width-1:0]    part_word;
    logic [pack-1:0]                    part_keep;
    logic                               full;
    logic                               out_free;
    logic                               load_full;

    // Counting the in-flight byte keeps the accumulator from ever overrunning.
    assign r_en = !empty && (state_q == FILL) && !flush_pend_q &&
                  ((CW1'(cnt_q) + CW1'(inflight_q)) < CW1'(pack));

    assign full      = (cnt_q == CW'(pack));
    assign out_free  = !m_valid_q || m_ready;
    assign load_full = full && out_free;

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_keep   = m_keep_q;
    assign word_cnt = word_cnt_q;
    assign busy     = (state_q != FILL);

    always_comb begin
        for (int i = 0; i < pack; i++) begin
            part_word[i] = (CW'(i) < cnt_q) ? acc_q[i] : '0;
            part_keep[i] = (CW'(i) < cnt_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inflight_d   = r_en;
        flush_pend_d = flush_pend_q;
        acc_d        = acc_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        word_cnt_d   = word_cnt_q;

        if (m_valid_q && m_ready) begin
            m_valid_d  = 1'b0;
            word_cnt_d = word_cnt_q + cnt_width'(1);
        end

        if (inflight_q) begin
            for (int i = 0; i < pack; i++) begin
                if (CW'(i) == cnt_q) acc_d[i] = fifo_data;
            end
            cnt_d = cnt_q + CW'(1);
        end

        if (load_full) begin
            m_data_d  = acc_q;
            m_keep_d  = '1;
            m_valid_d = 1'b1;
            cnt_d     = '0;
        end

        unique case (state_q)
            FILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q) begin
                    if (cnt_q == '0) begin
                        state_d      = FILL;
                        flush_pend_d = 1'b0;
                    end else if (full) begin
                        if (load_full) begin
                            state_d      = FILL;
                            flush_pend_d = 1'b0;
                        end
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_free) begin
                    m_data_d     = part_word;
                    m_keep_d     = part_keep;
                    m_valid_d    = 1'b1;
                    cnt_d        = '0;
                    state_d      = FILL;
                    flush_pend_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge rclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            acc_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inflight_q   <= inflight_d;
            flush_pend_q <= flush_pend_d;
            acc_q        <= acc_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

endmodule
